regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_sb.sv | 112 +++++++++++
 tb/tb_regfile_sb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
// Holds the parameter defaults used by regfile_sb and the state encoding of
// the register-clear sweep FSM.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NRD_DEF      = 2;
    localparam int ZERO_REG_DEF = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for regfile_sb.
// One busy bit per register marks a destination reserved by an issued
// instruction and not yet written back.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr_start       one-cycle pulse on the IDLE->CLEAR transition (drops all reservations)
//   clr_busy        clear sweep running: blocks issue, masks hazards, drops writes
//   we, waddr       write-back port (raw request)
//   raddr           packed read indices, NRD x ADDR_W
//   iss_valid/iss_rd  issue request and its destination
//   rhaz            per-read-port hazard
//   iss_ready       issue accepted this cycle
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_start,
    input  logic                  clr_busy,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [NRD*ADDR_W-1:0] raddr,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_rd,
    output logic [NRD-1:0]        rhaz,
    output logic                  iss_ready
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy;
    logic             wr_commit;
    logic             iss_set;

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    assign wr_commit = we & ~clr_busy & writable(waddr);

    // A write-back to the reserved register in the same cycle frees it,
    // so the WAW stall is released without waiting a cycle.
    assign iss_ready = ~clr_busy & (~busy[iss_rd] | (we & (waddr == iss_rd)));
    assign iss_set   = iss_valid & iss_ready & writable(iss_rd);

    // The set is written after the clear so a same-index reservation wins.
    always_ff @(posedge clk) begin
        if (rst || clr_start) begin
            busy <= '0;
        end else begin
            if (wr_commit) busy[waddr] <= 1'b0;
            if (iss_set)   busy[iss_rd] <= 1'b1;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra   = '0;
        rhaz = '0;
        for (int i = 0; i < NRD; i++) begin
            ra      = raddr[i*ADDR_W +: ADDR_W];
            rhaz[i] = ~clr_busy & writable(ra) & busy[ra] & ~(we & (waddr == ra));
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-back bypass, busy-bit scoreboard and a
// sequential clear sweep.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   we/waddr/wdata    write-back port
//   raddr/rdata       NRD combinational read ports, packed (port i at [i*W +: W])
//   rhaz              per-port pending-write hazard
//   iss_valid/iss_rd/iss_ready  destination reservation handshake
//   clr_req/clr_busy  start pulse and in-progress flag of the clear sweep
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rhaz,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_rd,
    output logic                  iss_ready,
    input  logic                  clr_req,
    output logic                  clr_busy
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] regs [DEPTH];
    clr_state_e        state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic              clr_start;
    logic              wr_commit;

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    assign clr_busy  = (state == ST_CLEAR);
    assign clr_start = (state == ST_IDLE) & clr_req;
    assign wr_commit = we & ~clr_busy & writable(waddr);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (clr_req) state_nx = ST_CLEAR;
            ST_CLEAR: if (cnt == CNT_LAST) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // cnt sits at 0 outside the sweep, so each sweep starts at register 0
    // and the counter never wraps on its own.
    always_ff @(posedge clk) begin
        if (rst)                                     cnt <= '0;
        else if (state == ST_CLEAR && cnt != CNT_LAST) cnt <= cnt + ADDR_W'(1);
        else                                         cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (clr_busy) begin
            regs[cnt] <= '0;
        end else if (wr_commit) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra    = '0;
        rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = raddr[i*ADDR_W +: ADDR_W];
            if (!clr_busy && writable(ra)) begin
                rdata[i*DATA_W +: DATA_W] = (we && waddr == ra) ? wdata : regs[ra];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .we        (we),
        .waddr     (waddr),
        .raddr     (raddr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rhaz      (rhaz),
        .iss_ready (iss_ready)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed vectors on the default configuration and
// model-driven traffic on a 3-read-port, 16-entry, 16-bit configuration.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default configuration: DATA_W=32, ADDR_W=5, NRD=2, ZERO_REG=1
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rhaz;
    logic        a_iss_valid;
    logic [4:0]  a_iss_rd;
    logic        a_iss_ready;
    logic        a_clr_req;
    logic        a_clr_busy;

    // small configuration: DATA_W=16, ADDR_W=4, NRD=3, ZERO_REG=1
    logic        b_we;
    logic [3:0]  b_waddr;
    logic [15:0] b_wdata;
    logic [11:0] b_raddr;
    logic [47:0] b_rdata;
    logic [2:0]  b_rhaz;
    logic        b_iss_valid;
    logic [3:0]  b_iss_rd;
    logic        b_iss_ready;
    logic        b_clr_req;
    logic        b_clr_busy;

    regfile_sb u_a (
        .clk       (clk),
        .rst       (rst),
        .we        (a_we),
        .waddr     (a_waddr),
        .wdata     (a_wdata),
        .raddr     (a_raddr),
        .rdata     (a_rdata),
        .rhaz      (a_rhaz),
        .iss_valid (a_iss_valid),
        .iss_rd    (a_iss_rd),
        .iss_ready (a_iss_ready),
        .clr_req   (a_clr_req),
        .clr_busy  (a_clr_busy)
    );

    regfile_sb #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .NRD      (3),
        .ZERO_REG (1)
    ) u_b (
        .clk       (clk),
        .rst       (rst),
        .we        (b_we),
        .waddr     (b_waddr),
        .wdata     (b_wdata),
        .raddr     (b_raddr),
        .rdata     (b_rdata),
        .rhaz      (b_rhaz),
        .iss_valid (b_iss_valid),
        .iss_rd    (b_iss_rd),
        .iss_ready (b_iss_ready),
        .clr_req   (b_clr_req),
        .clr_busy  (b_clr_busy)
    );

    typedef struct {
        string       name;
        bit          is_b;
        logic [95:0] rd;
        logic [2:0]  hz;
        logic        ir;
        logic        cb;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: every expectation queued in a cycle is checked at that
    // cycle's falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [95:0] ard;
        logic [2:0]  ahz;
        logic        air;
        logic        acb;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.is_b) begin
                ard = {48'b0, b_rdata};
                ahz = b_rhaz;
                air = b_iss_ready;
                acb = b_clr_busy;
            end else begin
                ard = {32'b0, a_rdata};
                ahz = {1'b0, a_rhaz};
                air = a_iss_ready;
                acb = a_clr_busy;
            end
            total++;
            if (ard !== e.rd || ahz !== e.hz || air !== e.ir || acb !== e.cb) begin
                bad++;
                $display("FAIL %s: got rdata=%h rhaz=%b iss_ready=%b clr_busy=%b, expected rdata=%h rhaz=%b iss_ready=%b clr_busy=%b",
                         e.name, ard, ahz, air, acb, e.rd, e.hz, e.ir, e.cb);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r0,
                         input logic iv, input logic [4:0] ird, input logic clr);
        a_we        = we;
        a_waddr     = wa;
        a_wdata     = wd;
        a_raddr     = {r1, r0};
        a_iss_valid = iv;
        a_iss_rd    = ird;
        a_clr_req   = clr;
    endtask

    task automatic push_a(input string nm, input logic [63:0] rd, input logic [1:0] hz,
                          input logic ir, input logic cb);
        exp_t e;
        e.name = nm;
        e.is_b = 1'b0;
        e.rd   = {32'b0, rd};
        e.hz   = {1'b0, hz};
        e.ir   = ir;
        e.cb   = cb;
        exp_q.push_back(e);
    endtask

    task automatic push_b(input string nm, input logic [47:0] rd, input logic [2:0] hz,
                          input logic ir);
        exp_t e;
        e.name = nm;
        e.is_b = 1'b1;
        e.rd   = {48'b0, rd};
        e.hz   = hz;
        e.ir   = ir;
        e.cb   = 1'b0;
        exp_q.push_back(e);
    endtask

    logic [15:0] m_regs [16];
    logic [15:0] m_busy;

    initial begin
        logic [31:0] v;
        logic [47:0] erd;
        logic [2:0]  ehz;
        logic [3:0]  ra;
        logic        erdy;

        rst = 1'b1;
        a_set(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        b_we = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
        b_iss_valid = 1'b0; b_iss_rd = '0; b_clr_req = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        // reset state
        a_set(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        push_a("reset_state", 64'h0, 2'b00, 1'b1, 1'b0);

        // write r5, same-cycle bypass on both ports, then registered read
        cyc();
        a_set(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
        push_a("bypass_r5", {32'hDEADBEEF, 32'hDEADBEEF}, 2'b00, 1'b1, 1'b0);
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
        push_a("read_r5", {32'hDEADBEEF, 32'hDEADBEEF}, 2'b00, 1'b1, 1'b0);

        // r0 ignores writes and reservations
        cyc();
        a_set(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        push_a("r0_write_nobypass", 64'h0, 2'b00, 1'b1, 1'b0);
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        push_a("r0_issue", 64'h0, 2'b00, 1'b1, 1'b0);
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        push_a("r0_after_issue", 64'h0, 2'b00, 1'b1, 1'b0);

        // scoreboard on r7
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b1, 5'd7, 1'b0);
        push_a("issue_r7", {32'h0, 32'hDEADBEEF}, 2'b00, 1'b1, 1'b0);
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
        push_a("r7_waw_stall", 64'h0, 2'b11, 1'b0, 1'b0);
        cyc();
        a_set(1'b1, 5'd7, 32'h0000A5A5, 5'd7, 5'd5, 1'b1, 5'd7, 1'b0);
        push_a("r7_wb_and_issue", {32'h0000A5A5, 32'hDEADBEEF}, 2'b00, 1'b1, 1'b0);
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        push_a("r7_still_busy", {32'h0000A5A5, 32'h0000A5A5}, 2'b11, 1'b0, 1'b0);
        cyc();
        a_set(1'b1, 5'd7, 32'h00000077, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        push_a("r7_wb_bypass", {32'h00000077, 32'h00000077}, 2'b00, 1'b1, 1'b0);
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        push_a("r7_freed", {32'h00000077, 32'h00000077}, 2'b00, 1'b1, 1'b0);

        // fill r1..r31
        for (int k = 1; k < 32; k++) begin
            cyc();
            v = 32'h01010101 * k;
            a_set(1'b1, 5'(k), v, 5'(k), 5'd0, 1'b0, 5'd0, 1'b0);
            push_a("fill", {v, 32'h0}, 2'b00, 1'b1, 1'b0);
        end

        // reserve r3, then start a sweep
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd3, 5'd1, 1'b1, 5'd3, 1'b0);
        push_a("issue_r3", {32'h03030303, 32'h01010101}, 2'b00, 1'b1, 1'b0);
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd3, 5'd1, 1'b0, 5'd3, 1'b1);
        push_a("clr_req_cycle", {32'h03030303, 32'h01010101}, 2'b10, 1'b0, 1'b0);
        for (int c = 0; c < 32; c++) begin
            cyc();
            a_set(1'b1, 5'd9, 32'hFFFFFFFF, 5'd9, 5'd1, 1'b1, 5'd2, (c == 5));
            push_a("sweep_active", 64'h0, 2'b00, 1'b0, 1'b1);
        end
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd3, 5'd9, 1'b0, 5'd3, 1'b0);
        push_a("sweep_end", 64'h0, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc();
            a_set(1'b0, 5'd0, 32'h0, 5'(i + 16), 5'(i), 1'b0, 5'd2, 1'b0);
            push_a("cleared_read", 64'h0, 2'b00, 1'b1, 1'b0);
        end

        // reset in the middle of a sweep
        cyc();
        a_set(1'b1, 5'd20, 32'h20202020, 5'd20, 5'd3, 1'b1, 5'd3, 1'b0);
        push_a("pre_rst_write", {32'h20202020, 32'h0}, 2'b00, 1'b1, 1'b0);
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd20, 5'd3, 1'b0, 5'd3, 1'b0);
        push_a("pre_rst_read", {32'h20202020, 32'h0}, 2'b01, 1'b0, 1'b0);
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd20, 5'd3, 1'b0, 5'd3, 1'b1);
        for (int c = 0; c < 10; c++) begin
            cyc();
            a_set(1'b0, 5'd0, 32'h0, 5'd20, 5'd3, 1'b0, 5'd3, 1'b0);
        end
        cyc();
        rst = 1'b1;
        a_set(1'b1, 5'd4, 32'h00000044, 5'd20, 5'd3, 1'b1, 5'd6, 1'b1);
        cyc();
        rst = 1'b0;
        a_set(1'b0, 5'd0, 32'h0, 5'd20, 5'd3, 1'b0, 5'd3, 1'b0);
        push_a("after_mid_sweep_rst", 64'h0, 2'b00, 1'b1, 1'b0);
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b0, 5'd6, 1'b0);
        push_a("rst_priority", 64'h0, 2'b00, 1'b1, 1'b0);

        // traffic on the small configuration against a reference model
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_busy = '0;
        cyc();
        a_set(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            cyc();
            b_we        = 1'($urandom_range(0, 1));
            b_waddr     = 4'($urandom_range(0, 15));
            b_wdata     = 16'($urandom);
            b_raddr     = 12'($urandom);
            b_iss_valid = 1'($urandom_range(0, 1));
            b_iss_rd    = 4'($urandom_range(0, 15));
            erd = '0;
            ehz = '0;
            for (int p = 0; p < 3; p++) begin
                ra = b_raddr[p*4 +: 4];
                if (ra != 4'd0) begin
                    erd[p*16 +: 16] = (b_we && b_waddr == ra) ? b_wdata : m_regs[ra];
                    ehz[p] = m_busy[ra] && !(b_we && b_waddr == ra);
                end
            end
            erdy = !m_busy[b_iss_rd] || (b_we && b_waddr == b_iss_rd);
            push_b("model_traffic", erd, ehz, erdy);
            if (b_we && b_waddr != 4'd0) begin
                m_regs[b_waddr] = b_wdata;
                m_busy[b_waddr] = 1'b0;
            end
            if (b_iss_valid && erdy && b_iss_rd != 4'd0) m_busy[b_iss_rd] = 1'b1;
        end

        cyc();
        b_we = 1'b0;
        b_iss_valid = 1'b0;
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
